// File: rtl/gpool_mc.sv
// Multi-channel global pooling stage. It pools a channel-interleaved stream of signed samples
// into one average or max result per channel, and emits the results in channel order.
module gpool_mc #(
  parameter int DATA_WIDTH = 12,
  parameter int POOL_SIZE  = 250,
  parameter int CHANNELS   = 8,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int ACC_W     = DATA_WIDTH + $clog2(POOL_SIZE) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode_in,
  output logic                         gpool_ready_in,
  input  logic                         gpool_valid_in,
  input  logic signed [DATA_WIDTH-1:0] gpool_data_in,
  input  logic                         gpool_ready_out,
  output logic                         gpool_valid_out,
  output logic signed [DATA_WIDTH-1:0] gpool_data_out,
  output logic [CH_W-1:0]              gpool_chan_out,
  output logic                         gpool_last_out,
  output logic                         gpool_busy
);

  localparam int T_W   = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [ACC_W:0]    DIVISOR = (ACC_W + 1)'(POOL_SIZE);
  localparam logic [CH_W-1:0]   LAST_CH = CH_W'(CHANNELS - 1);
  localparam logic [T_W-1:0]    LAST_T  = T_W'(POOL_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DRAIN} state_t;

  state_t                  state, state_d;
  logic                    mode_r;
  logic [CH_W-1:0]         ch;
  logic [T_W-1:0]          t;
  logic signed [ACC_W-1:0] acc [CHANNELS];
  logic [ACC_W-1:0]        div_q, div_rem;
  logic [CNT_W-1:0]        div_cnt;
  logic                    div_run, div_neg;
  logic signed [DATA_WIDTH-1:0] data_r;

  logic                    in_fire, out_fire, last_ch, frame_done, div_last, div_ge;
  logic signed [ACC_W-1:0] sample_ext, acc_cur;
  logic [ACC_W-1:0]        acc_mag, rem_nx, q_nx;
  logic [ACC_W:0]          rem_sh;

  assign in_fire    = gpool_valid_in && gpool_ready_in;
  assign out_fire   = gpool_valid_out && gpool_ready_out;
  assign last_ch    = (ch == LAST_CH);
  assign frame_done = last_ch && (t == LAST_T);
  assign sample_ext = ACC_W'(gpool_data_in);
  assign acc_cur    = acc[ch];
  assign acc_mag    = acc_cur[ACC_W-1] ? -acc_cur : acc_cur;

  // Restoring divide on the magnitude: the dividend shifts out of div_q's top while the
  // quotient bits shift in at the bottom; the sign is reapplied so results truncate toward zero.
  assign rem_sh   = {div_rem, div_q[ACC_W-1]};
  assign div_ge   = (rem_sh >= DIVISOR);
  assign rem_nx   = div_ge ? ACC_W'(rem_sh - DIVISOR) : ACC_W'(rem_sh);
  assign q_nx     = {div_q[ACC_W-2:0], div_ge};
  assign div_last = div_run && (div_cnt == CNT_W'(1));

  assign gpool_data_out = data_r;
  assign gpool_chan_out = ch;

  // NOTE: every output is written in every branch, with a default first, so no latch can be inferred.
  always_comb begin
    state_d         = state;
    gpool_ready_in  = 1'b0;
    gpool_valid_out = 1'b0;
    gpool_last_out  = 1'b0;
    gpool_busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        gpool_ready_in = !rst;
        if (in_fire) state_d = frame_done ? DIVIDE : ACCUM;
      end
      ACCUM: begin
        gpool_ready_in = !rst;
        if (in_fire && frame_done) state_d = DIVIDE;
      end
      DIVIDE: begin
        if (mode_r || div_last) state_d = DRAIN;
      end
      DRAIN: begin
        gpool_valid_out = 1'b1;
        gpool_last_out  = last_ch;
        if (out_fire) state_d = last_ch ? IDLE : DIVIDE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mode_r  <= 1'b0;
      ch      <= '0;
      t       <= '0;
      div_q   <= '0;
      div_rem <= '0;
      div_cnt <= '0;
      div_run <= 1'b0;
      div_neg <= 1'b0;
      data_r  <= '0;
      // NOTE: the accumulator array is cleared on reset. It is small, and this keeps an aborted frame from leaking state.
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else begin
      state <= state_d;
      unique case (state)
        IDLE, ACCUM: begin
          if (in_fire) begin
            if (state == IDLE) mode_r <= mode_in;
            if (t == '0)                    acc[ch] <= sample_ext;
            else if (!mode_r)               acc[ch] <= acc_cur + sample_ext;
            else if (sample_ext > acc_cur)  acc[ch] <= sample_ext;
            if (last_ch) begin
              ch <= '0;
              t  <= frame_done ? '0 : t + T_W'(1);
            end else begin
              ch <= ch + CH_W'(1);
            end
          end
        end
        DIVIDE: begin
          if (mode_r) begin
            data_r <= DATA_WIDTH'(acc_cur);
          end else if (!div_run) begin
            div_run <= 1'b1;
            div_q   <= acc_mag;
            div_rem <= '0;
            div_cnt <= CNT_W'(ACC_W);
            div_neg <= acc_cur[ACC_W-1];
          end else begin
            div_q   <= q_nx;
            div_rem <= rem_nx;
            div_cnt <= div_cnt - CNT_W'(1);
            if (div_last) begin
              div_run <= 1'b0;
              data_r  <= DATA_WIDTH'(div_neg ? -q_nx : q_nx);
            end
          end
        end
        DRAIN: begin
          if (out_fire) ch <= last_ch ? '0 : ch + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpool_mc.sv
// Scoreboard bench for gpool_mc. It drives three instances: 2ch x 4, 8ch x 250 and 1ch x 4.
// The stimulus process pushes the expected results, and a monitor pops and compares them on every output beat.
module tb_gpool_mc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                valid_in  [3];
  logic                ready_in  [3];
  logic                mode      [3];
  logic                ready_out [3];
  logic                valid_out [3];
  logic                last_out  [3];
  logic                busy      [3];
  logic signed [11:0]  data_in   [3];
  logic signed [11:0]  data_out  [3];
  logic [2:0]          chan      [3];
  logic [0:0]          chan_a, chan_c;
  logic [2:0]          chan_b;

  assign chan[0] = {2'b00, chan_a};
  assign chan[1] = chan_b;
  assign chan[2] = {2'b00, chan_c};

  gpool_mc #(.DATA_WIDTH(12), .POOL_SIZE(4), .CHANNELS(2)) u_a (
    .clk(clk), .rst(rst), .mode_in(mode[0]), .gpool_ready_in(ready_in[0]),
    .gpool_valid_in(valid_in[0]), .gpool_data_in(data_in[0]), .gpool_ready_out(ready_out[0]),
    .gpool_valid_out(valid_out[0]), .gpool_data_out(data_out[0]), .gpool_chan_out(chan_a),
    .gpool_last_out(last_out[0]), .gpool_busy(busy[0]));

  gpool_mc #(.DATA_WIDTH(12), .POOL_SIZE(250), .CHANNELS(8)) u_b (
    .clk(clk), .rst(rst), .mode_in(mode[1]), .gpool_ready_in(ready_in[1]),
    .gpool_valid_in(valid_in[1]), .gpool_data_in(data_in[1]), .gpool_ready_out(ready_out[1]),
    .gpool_valid_out(valid_out[1]), .gpool_data_out(data_out[1]), .gpool_chan_out(chan_b),
    .gpool_last_out(last_out[1]), .gpool_busy(busy[1]));

  gpool_mc #(.DATA_WIDTH(12), .POOL_SIZE(4), .CHANNELS(1)) u_c (
    .clk(clk), .rst(rst), .mode_in(mode[2]), .gpool_ready_in(ready_in[2]),
    .gpool_valid_in(valid_in[2]), .gpool_data_in(data_in[2]), .gpool_ready_out(ready_out[2]),
    .gpool_valid_out(valid_out[2]), .gpool_data_out(data_out[2]), .gpool_chan_out(chan_c),
    .gpool_last_out(last_out[2]), .gpool_busy(busy[2]));

  typedef struct {
    int unit;
    int data;
    int chan;
    int last;
  } exp_t;

  exp_t exp_q[$];
  int   stim[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: awaited event did not occur (t=%0t)", name, $time);
  endtask

  task automatic push(input int u, input int d, input int c, input int l);
    exp_t e;
    e.unit = u; e.data = d; e.chan = c; e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic send_beat(input int u, input int s, input bit m);
    bit ok = 1'b0;
    valid_in[u] = 1'b1;
    data_in[u]  = 12'(s);
    mode[u]     = m;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      ok = ready_in[u];
      @(posedge clk);
      #1;
    end
    valid_in[u] = 1'b0;
    if (!ok) fail("input_accept_timeout");
  endtask

  // Plays the stim queue into unit u. The mode may toggle every beat, and random idle gaps may be inserted.
  task automatic play(input int u, input bit m, input bit toggle, input int max_gap);
    foreach (stim[i]) begin
      int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      send_beat(u, stim[i], m ^ (toggle && (i % 2 == 1)));
    end
    stim.delete();
  endtask

  task automatic wait_valid(input int u);
    bit ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      if (valid_out[u]) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) fail("valid_out_timeout");
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int k = 0; k < 4000 && !ok; k++) begin
      if (exp_q.size() == 0 && !busy[0] && !busy[1] && !busy[2]) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) fail("drain_timeout");
  endtask

  // The monitor runs on the falling edge, while every input is driven just after the rising edge.
  logic               held      [3];
  logic signed [11:0] held_data [3];
  logic [2:0]         held_chan [3];
  logic               held_last [3];

  initial begin : monitor
    exp_t e;
    for (int u = 0; u < 3; u++) held[u] = 1'b0;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 3; u++) begin
        if (valid_out[u] === 1'b1) begin
          check("ready_in_low_while_output", int'(ready_in[u]), 0);
          if (held[u]) begin
            check("stall_data_stable", data_out[u], held_data[u]);
            check("stall_chan_stable", int'(chan[u]), int'(held_chan[u]));
            check("stall_last_stable", int'(last_out[u]), int'(held_last[u]));
          end
          if (ready_out[u]) begin
            held[u] = 1'b0;
            if (exp_q.size() == 0) fail("unexpected_output");
            else begin
              e = exp_q.pop_front();
              check("out_unit", u, e.unit);
              check("out_data", data_out[u], e.data);
              check("out_chan", int'(chan[u]), e.chan);
              check("out_last", int'(last_out[u]), e.last);
            end
          end else begin
            held[u]      = 1'b1;
            held_data[u] = data_out[u];
            held_chan[u] = chan[u];
            held_last[u] = last_out[u];
          end
        end else begin
          held[u] = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      valid_in[u] = 1'b0; data_in[u] = '0; mode[u] = 1'b0; ready_out[u] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      check("rst_ready_in", int'(ready_in[u]), 0);
      check("rst_valid_out", int'(valid_out[u]), 0);
      check("rst_data_out", data_out[u], 0);
      check("rst_chan_out", int'(chan[u]), 0);
      check("rst_last_out", int'(last_out[u]), 0);
      check("rst_busy", int'(busy[u]), 0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) check("ready_in_after_rst", int'(ready_in[u]), 1);

    // Average mode: 100/4 = 25, and -9/4 truncates toward zero to -2.
    push(0, 25, 0, 0); push(0, -2, 1, 1);
    stim = '{10, -1, 20, -2, 30, -3, 40, -3};
    play(0, 1'b0, 1'b0, 0);
    wait_drain();

    // Max mode, with mode_in toggled on every beat after the first.
    push(0, -2, 0, 0); push(0, 100, 1, 1);
    stim = '{-5, 3, -7, 3, -2, 100, -9, -100};
    play(0, 1'b1, 1'b1, 0);
    wait_drain();

    // Backpressure: each output is stalled for 20 cycles. The sums are 5/4 = 1 and -31/4 = -7.
    ready_out[0] = 1'b0;
    push(0, 1, 0, 0); push(0, -7, 1, 1);
    stim = '{1, -8, 1, -8, 1, -8, 2, -7};
    play(0, 1'b0, 1'b0, 0);
    for (int o = 0; o < 2; o++) begin
      wait_valid(0);
      repeat (20) @(posedge clk);
      #1;
      check("ready_in_low_stalled", int'(ready_in[0]), 0);
      ready_out[0] = 1'b1;
      @(posedge clk);
      #1;
      ready_out[0] = 1'b0;
    end
    ready_out[0] = 1'b1;
    wait_drain();
    check("ready_in_after_drain", int'(ready_in[0]), 1);

    // Three back-to-back frames with random gaps and modes avg, max, avg.
    push(0, 250, 0, 0); push(0, -100, 1, 1);
    stim = '{100, -100, 200, -100, 300, -100, 401, -101};
    play(0, 1'b0, 1'b0, 3);
    push(0, -2047, 0, 0); push(0, 2047, 1, 1);
    stim = '{-2048, 2047, -2048, 0, -2048, 0, -2047, 0};
    play(0, 1'b1, 1'b0, 3);
    push(0, 2047, 0, 0); push(0, -2048, 1, 1);
    stim = '{2047, -2048, 2047, -2048, 2047, -2048, 2047, -2048};
    play(0, 1'b0, 1'b0, 3);
    wait_drain();

    // Full-size configuration at both extremes of the sample range.
    for (int pass = 0; pass < 2; pass++) begin
      int v = (pass == 0) ? -2048 : 2047;
      for (int c = 0; c < 8; c++) push(1, v, c, int'(c == 7));
      for (int i = 0; i < 2000; i++) stim.push_back(v);
      play(1, 1'b0, 1'b0, 0);
      wait_drain();
    end

    // Reset during ACCUM.
    stim = '{1, 2};
    play(2, 1'b0, 1'b0, 0);
    check("busy_in_accum", int'(busy[2]), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_accum_valid_out", int'(valid_out[2]), 0);
    check("rst_accum_busy", int'(busy[2]), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_accum_ready_in", int'(ready_in[2]), 1);

    // Reset during DRAIN, while the pending output is stalled.
    ready_out[2] = 1'b0;
    stim = '{5, 6, 7, 8};
    play(2, 1'b0, 1'b0, 0);
    wait_valid(2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_drain_valid_out", int'(valid_out[2]), 0);
    check("rst_drain_busy", int'(busy[2]), 0);
    check("rst_drain_data_out", data_out[2], 0);
    rst = 1'b0;
    ready_out[2] = 1'b1;
    @(posedge clk);
    #1;

    // A clean frame after the resets: (1+2+3+4)/4 truncates to 2.
    push(2, 2, 0, 1);
    stim = '{1, 2, 3, 4};
    play(2, 1'b0, 1'b0, 0);
    wait_drain();

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
